fir_result_buffer: RTL and testbench

//  Downstream stage of the FIR top. Captures each RESULT word qualified by OUTPUT_DATA_READY
//  (one result per 4-cycle FIR frame), rescales it by an arithmetic right shift and saturates
//  it to OUT_W bits. Buffers results in a small FIFO and presents them on a valid/ready port.

---
 rtl/fir_pkg.sv | 42 ++++
 rtl/fir_out_fifo.sv | 60 ++++++
 rtl/fir_result_buffer.sv | 83 ++++++++
 tb/tb_fir_result_buffer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared FIR definitions: result/output widths, FIR state codes and the
// rescale-and-saturate helper used by the result buffer.
package fir_pkg;

    localparam int unsigned FIR_RESULT_W = 32;
    localparam int unsigned FIR_OUT_W    = 16;

    localparam logic [2:0] FIR_ST_RESET  = 3'd0;
    localparam logic [2:0] FIR_ST_FIRST  = 3'd1;
    localparam logic [2:0] FIR_ST_SECOND = 3'd2;
    localparam logic [2:0] FIR_ST_THIRD  = 3'd3;
    localparam logic [2:0] FIR_ST_OUTPUT = 3'd4;

    typedef struct packed {
        logic        sat;
        logic [63:0] data;
    } fir_scaled_t;

    // value must be sign-extended to 64 bits; out_w must be 1..63.
    function automatic fir_scaled_t fir_sat_scale(input logic signed [63:0] value,
                                                  input int unsigned shift,
                                                  input int unsigned out_w);
        logic signed [63:0] s;
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        fir_scaled_t        r;
        s      = value >>> shift;
        max_v  = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        min_v  = -(64'sd1 <<< (out_w - 1));
        r.sat  = 1'b0;
        r.data = s;
        if (s > max_v) begin
            r.sat  = 1'b1;
            r.data = max_v;
        end else if (s < min_v) begin
            r.sat  = 1'b1;
            r.data = min_v;
        end
        return r;
    endfunction

endpackage

// File: rtl/fir_out_fifo.sv
// First-word-fall-through FIFO holding scaled FIR results.
// A write into a full FIFO is accepted only when a pop happens on the same edge.
module fir_out_fifo #(
    parameter int unsigned Depth = 8,
    parameter int unsigned Width = 17
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     wr_i,
    input  logic [Width-1:0]         wdata_i,
    input  logic                     rd_i,
    output logic [Width-1:0]         rdata_o,
    output logic                     valid_o,
    output logic                     full_o,
    output logic [$clog2(Depth):0]   count_o
);
    localparam int unsigned AW = $clog2(Depth);
    localparam logic [AW:0] FullCount = (AW + 1)'(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_wr, do_rd;

    assign valid_o = (count_q != '0);
    assign full_o  = (count_q == FullCount);
    assign count_o = count_q;
    assign do_rd   = rd_i & valid_o;
    assign do_wr   = wr_i & (~full_o | do_rd);
    assign rdata_o = valid_o ? mem_q[rptr_q] : '0;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_wr) wptr_d = wptr_q + 1'b1;
        if (do_rd) rptr_d = rptr_q + 1'b1;
        if (do_wr && !do_rd) count_d = count_q + 1'b1;
        if (!do_wr && do_rd) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: reads are masked while empty.
    always_ff @(posedge clk_i) begin
        if (do_wr) mem_q[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/fir_result_buffer.sv
// Captures FIR results, rescales and saturates them, and buffers them for a
// valid/ready consumer; results arriving while the buffer is full are counted.
module fir_result_buffer
    import fir_pkg::*;
#(
    parameter int unsigned IN_W  = FIR_RESULT_W,
    parameter int unsigned OUT_W = FIR_OUT_W,
    parameter int unsigned SHIFT = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     in_dv_i,
    input  logic [IN_W-1:0]          in_result_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [OUT_W-1:0]         out_data_o,
    output logic                     out_sat_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [15:0]              ovf_cnt_o,
    input  logic                     clear_ovf_i
);
    fir_scaled_t      scaled;
    logic             s1_v_q;
    logic [OUT_W-1:0] s1_data_q;
    logic             s1_sat_q;
    logic [15:0]      ovf_cnt_q, ovf_cnt_d;
    logic             full, pop, drop;
    logic             unused_scaled_hi;

    always_comb scaled = fir_sat_scale(64'($signed(in_result_i)), SHIFT, OUT_W);
    assign unused_scaled_hi = ^scaled.data[63:OUT_W];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_v_q    <= 1'b0;
            s1_data_q <= '0;
            s1_sat_q  <= 1'b0;
        end else begin
            s1_v_q <= in_dv_i;
            if (in_dv_i) begin
                s1_data_q <= scaled.data[OUT_W-1:0];
                s1_sat_q  <= scaled.sat;
            end
        end
    end

    assign pop  = out_valid_o & out_ready_i;
    assign drop = s1_v_q & full & ~pop;

    fir_out_fifo #(
        .Depth (DEPTH),
        .Width (OUT_W + 1)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .wr_i    (s1_v_q),
        .wdata_i ({s1_sat_q, s1_data_q}),
        .rd_i    (pop),
        .rdata_o ({out_sat_o, out_data_o}),
        .valid_o (out_valid_o),
        .full_o  (full),
        .count_o (count_o)
    );

    // A clear coinciding with a drop still records that drop.
    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        if (clear_ovf_i) begin
            ovf_cnt_d = drop ? 16'd1 : 16'd0;
        end else if (drop && ovf_cnt_q != 16'hFFFF) begin
            ovf_cnt_d = ovf_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) ovf_cnt_q <= '0;
        else         ovf_cnt_q <= ovf_cnt_d;
    end

    assign ovf_cnt_o = ovf_cnt_q;

endmodule

// File: tb/tb_fir_result_buffer.sv
// Directed bench for fir_result_buffer (SHIFT=8, OUT_W=16, DEPTH=8).
module tb_fir_result_buffer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_dv;
    logic [31:0] in_result;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_sat;
    logic [3:0]  count;
    logic [15:0] ovf_cnt;
    logic        clear_ovf;

    int checks = 0;
    int errors = 0;

    fir_result_buffer #(
        .IN_W  (32),
        .OUT_W (16),
        .SHIFT (8),
        .DEPTH (8)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_dv_i     (in_dv),
        .in_result_i (in_result),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_sat_o   (out_sat),
        .count_o     (count),
        .ovf_cnt_o   (ovf_cnt),
        .clear_ovf_i (clear_ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [31:0] v);
        in_dv     = 1'b1;
        in_result = v;
        tick();
        in_dv     = 1'b0;
        in_result = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_dv = 1'b0; in_result = '0; out_ready = 1'b0; clear_ovf = 1'b0;
        #12;
        checks++;
        if ({out_valid, count, ovf_cnt, out_data, out_sat} !== 38'd0) begin
            errors++;
            $display("FAIL reset valid=%b count=%0d ovf=%h data=%h sat=%b want all 0",
                     out_valid, count, ovf_cnt, out_data, out_sat);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        strobe(32'h0001_2345);
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h0123 || out_sat !== 1'b0) begin
            errors++;
            $display("FAIL basic valid=%b data=%h sat=%b want 1 0123 0", out_valid, out_data, out_sat);
        end
        tick();
        checks++;
        if (count !== 4'd0 || out_valid !== 1'b0 || out_data !== 16'h0) begin
            errors++;
            $display("FAIL basic_pop count=%0d valid=%b data=%h want 0 0 0000",
                     count, out_valid, out_data);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_saturation();
        logic [31:0] ins [3];
        logic [16:0] exp [3];
        ins = '{32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FF00};
        exp = '{{1'b1, 16'h7FFF}, {1'b1, 16'h8000}, {1'b0, 16'hFFFF}};
        for (int i = 0; i < 3; i++) strobe(ins[i]);
        tick();
        tick();
        checks++;
        if (out_data !== 16'h7FFF) begin
            errors++;
            $display("FAIL hold_stable data=%h want 7fff", out_data);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_valid !== 1'b1 || {out_sat, out_data} !== exp[i]) begin
                errors++;
                $display("FAIL sat_%0d valid=%b sat=%b data=%h want sat=%b data=%h",
                         i, out_valid, out_sat, out_data, exp[i][16], exp[i][15:0]);
            end
            out_ready = 1'b1; tick(); out_ready = 1'b0;
        end
    endtask

    task automatic test_overflow();
        for (int k = 1; k <= 9; k++) begin
            strobe(32'(k) << 8);
            tick(); tick(); tick();
        end
        checks++;
        if (count !== 4'd8 || ovf_cnt !== 16'd1) begin
            errors++;
            $display("FAIL ovf_fill count=%0d ovf=%0d want 8 1", count, ovf_cnt);
        end
        for (int k = 1; k <= 8; k++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 16'(k)) begin
                errors++;
                $display("FAIL ovf_drain_%0d valid=%b data=%h want 1 %h", k, out_valid, out_data, 16'(k));
            end
            out_ready = 1'b1; tick(); out_ready = 1'b0;
        end
        checks++;
        if (count !== 4'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL ovf_empty count=%0d valid=%b want 0 0", count, out_valid);
        end
    endtask

    task automatic test_full_pop();
        for (int k = 0; k < 8; k++) strobe(32'(16'h10 + k) << 8);
        tick();
        strobe(32'h0000_2000);
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        checks++;
        if (count !== 4'd8 || ovf_cnt !== 16'd1) begin
            errors++;
            $display("FAIL full_pop count=%0d ovf=%0d want 8 1", count, ovf_cnt);
        end
        for (int k = 1; k <= 8; k++) begin
            logic [15:0] e;
            e = (k == 8) ? 16'h0020 : 16'(16'h10 + k);
            checks++;
            if (out_valid !== 1'b1 || out_data !== e) begin
                errors++;
                $display("FAIL full_pop_order_%0d data=%h want %h", k, out_data, e);
            end
            out_ready = 1'b1; tick(); out_ready = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        in_dv = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            in_result = (k <= 3) ? (32'(k) << 8) : 32'h0;
            if (k == 4) in_dv = 1'b0;
            tick();
            if (k >= 2) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== 16'(k - 1)) begin
                    errors++;
                    $display("FAIL b2b_%0d valid=%b data=%h want 1 %h", k, out_valid, out_data, 16'(k - 1));
                end
            end
        end
        tick();
        checks++;
        if (count !== 4'd0) begin
            errors++;
            $display("FAIL b2b_empty count=%0d want 0", count);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        for (int k = 1; k <= 3; k++) strobe(32'(k) << 8);
        tick();
        strobe(32'h0000_7700);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || count !== 4'd0 || ovf_cnt !== 16'd0) begin
            errors++;
            $display("FAIL async_reset valid=%b count=%0d ovf=%0d want 0 0 0", out_valid, count, ovf_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick(); tick(); tick();
        checks++;
        if (out_valid !== 1'b0 || count !== 4'd0) begin
            errors++;
            $display("FAIL inflight_dropped valid=%b count=%0d want 0 0", out_valid, count);
        end
    endtask

    task automatic test_clear_ovf();
        for (int k = 1; k <= 13; k++) strobe(32'(k) << 8);
        tick();
        checks++;
        if (count !== 4'd8 || ovf_cnt !== 16'd5) begin
            errors++;
            $display("FAIL burst count=%0d ovf=%0d want 8 5", count, ovf_cnt);
        end
        strobe(32'h0000_6300);
        clear_ovf = 1'b1; tick(); clear_ovf = 1'b0;
        checks++;
        if (ovf_cnt !== 16'd1) begin
            errors++;
            $display("FAIL clear_with_drop ovf=%0d want 1", ovf_cnt);
        end
        clear_ovf = 1'b1; tick(); clear_ovf = 1'b0;
        checks++;
        if (ovf_cnt !== 16'd0) begin
            errors++;
            $display("FAIL clear_alone ovf=%0d want 0", ovf_cnt);
        end
        checks++;
        if (out_data !== 16'h0001 || out_sat !== 1'b0) begin
            errors++;
            $display("FAIL burst_head data=%h sat=%b want 0001 0", out_data, out_sat);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) tick();
        out_ready = 1'b0;
        checks++;
        if (count !== 4'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL burst_drain count=%0d valid=%b want 0 0", count, out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_overflow();
        test_full_pop();
        test_back_to_back();
        test_async_reset();
        test_clear_ovf();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
